frame_writer: RTL

Raster frame generator on the write side of the double-buffered frame store. One request from the display side makes it sweep every pixel of a HSIZE×VSIZE frame in raster order on clk_wr. For each pixel it presents coordinates plus a 12-bit RGB444 colour for background, net, player and ball. It then pulses write_finished so the frame store swaps its write and read buffers.

---
 rtl/frame_writer_if.sv | 18 +
 rtl/frame_writer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/frame_writer_if.sv
// Pixel write bus from the frame generator into the double-buffered frame store.
interface frame_writer_if #(
    parameter int unsigned COOR_WIDTH = 12
) ();
    logic [COOR_WIDTH-1:0] write_x;
    logic [COOR_WIDTH-1:0] write_y;
    logic [11:0]           write_pixel;
    logic                  write_valid;
    logic                  write_finished;

    modport master (
        output write_x, write_y, write_pixel, write_valid, write_finished
    );

    modport slave (
        input write_x, write_y, write_pixel, write_valid, write_finished
    );
endinterface

// File: rtl/frame_writer.sv
// Raster frame generator: on each synchronised frame_req rising edge, sweeps one
// HSIZE x VSIZE frame of background/net/player/ball colours, then pulses write_finished.
module frame_writer #(
    parameter int unsigned COOR_WIDTH   = 12,
    parameter int unsigned HSIZE        = 720,
    parameter int unsigned VSIZE        = 540,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PLAYER_W     = 24,
    parameter int unsigned PLAYER_H     = 48,
    parameter int unsigned NET_X        = 356,
    parameter int unsigned NET_W        = 8,
    parameter logic [11:0] BG_COLOR     = 12'h0A2,
    parameter logic [11:0] NET_COLOR    = 12'hFFF,
    parameter logic [11:0] PLAYER_COLOR = 12'h00F,
    parameter logic [11:0] BALL_COLOR   = 12'hFF0
) (
    input  logic                  clk_wr,
    input  logic                  rst_n,
    input  logic                  frame_req,
    input  logic [COOR_WIDTH-1:0] ball_x,
    input  logic [COOR_WIDTH-1:0] ball_y,
    input  logic [COOR_WIDTH-1:0] player_x,
    input  logic [COOR_WIDTH-1:0] player_y,
    frame_writer_if.master        wr,
    output logic                  busy,
    output logic                  frame_overrun
);
    localparam int unsigned CW = COOR_WIDTH;
    localparam int unsigned EW = COOR_WIDTH + 1;

    typedef logic [CW-1:0] coor_t;
    typedef logic [EW-1:0] ext_t;

    localparam coor_t X_LAST = coor_t'(HSIZE - 1);
    localparam coor_t Y_LAST = coor_t'(VSIZE - 1);

    typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

    state_t      state_q, state_d;
    logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic        start_c;
    coor_t       bx_q, bx_d, by_q, by_d, px_q, px_d, py_q, py_d;
    coor_t       x_q, x_d, y_q, y_d;
    logic [11:0] pix_q, pix_d;
    logic        valid_q, valid_d, fin_q, fin_d, busy_q, busy_d, ovr_q, ovr_d;

    // Widened compare so pos + size cannot wrap back into the frame.
    function automatic logic in_span(input coor_t c, input coor_t pos, input int unsigned size);
        return ({1'b0, c} >= {1'b0, pos}) && ({1'b0, c} < ({1'b0, pos} + ext_t'(size)));
    endfunction

    function automatic logic [11:0] pixel_color(input coor_t x, input coor_t y,
                                                input coor_t bx, input coor_t by,
                                                input coor_t px, input coor_t py);
        if (in_span(x, bx, BALL_SIZE) && in_span(y, by, BALL_SIZE))
            return BALL_COLOR;
        else if (in_span(x, px, PLAYER_W) && in_span(y, py, PLAYER_H))
            return PLAYER_COLOR;
        else if (in_span(x, coor_t'(NET_X), NET_W))
            return NET_COLOR;
        else
            return BG_COLOR;
    endfunction

    always_comb begin
        s1_d    = frame_req;
        s2_d    = s1_q;
        s3_d    = s2_q;
        start_c = s2_q & ~s3_q;

        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        px_d    = px_q;
        py_d    = py_q;
        x_d     = x_q;
        y_d     = y_q;
        pix_d   = pix_q;
        valid_d = 1'b0;
        fin_d   = 1'b0;
        ovr_d   = start_c && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                x_d   = '0;
                y_d   = '0;
                pix_d = '0;
                if (start_c) state_d = LATCH;
            end
            LATCH: begin
                // Colour of (0,0) uses the positions being captured on this same edge.
                bx_d    = ball_x;
                by_d    = ball_y;
                px_d    = player_x;
                py_d    = player_y;
                x_d     = '0;
                y_d     = '0;
                valid_d = 1'b1;
                pix_d   = pixel_color('0, '0, ball_x, ball_y, player_x, player_y);
                state_d = DRAW;
            end
            DRAW: begin
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    fin_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    valid_d = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + coor_t'(1);
                    end else begin
                        x_d = x_q + coor_t'(1);
                    end
                    pix_d = pixel_color(x_d, y_d, bx_q, by_q, px_q, py_q);
                end
            end
            DONE: begin
                x_d     = '0;
                y_d     = '0;
                pix_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            px_q    <= px_d;
            py_q    <= py_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign wr.write_x        = x_q;
    assign wr.write_y        = y_q;
    assign wr.write_pixel    = pix_q;
    assign wr.write_valid    = valid_q;
    assign wr.write_finished = fin_q;
    assign busy              = busy_q;
    assign frame_overrun     = ovr_q;
endmodule
